// File: rtl/gf_exp.sv
// GF(2^8) antilog unit (poly 0x11D, alpha = 0x02): builds a 255-entry alpha^k
// table after reset, then serves one exponent lookup per cycle with valid/ready handshakes.
module gf_exp (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [7:0] in,
    input  logic       req_zero,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] out,
    output logic       init_done
);

    typedef enum logic {
        INIT,
        SERVE
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] k;
    logic [7:0] v;
    logic [7:0] tbl [0:254];
    logic [7:0] idx;
    logic       accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= INIT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            INIT:    if (k == 8'd254) state_next = SERVE;
            SERVE:   state_next = SERVE;
            default: state_next = INIT;
        endcase
    end

    always_comb begin
        init_done = (state == SERVE);
        req_ready = (state == SERVE) && (!rsp_valid || rsp_ready);
    end

    // k stops at the last index so the table write below never leaves the array.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k <= 8'd0;
            v <= 8'h01;
        end else if (state == INIT) begin
            if (k != 8'd254) k <= k + 8'd1;
            v <= {v[6:0], 1'b0} ^ (v[7] ? 8'h1D : 8'h00);
        end
    end

    always_ff @(posedge clk) begin
        if (state == INIT) tbl[k] <= v;
    end

    // alpha^255 == alpha^0, so exponent 255 folds onto entry 0.
    assign idx    = (in == 8'hFF) ? 8'h00 : in;
    assign accept = req_valid && req_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            out       <= 8'h00;
        end else if (accept) begin
            rsp_valid <= 1'b1;
            out       <= req_zero ? 8'h00 : tbl[idx];
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_gf_exp.sv
// Directed self-checking bench for gf_exp: init timing, streaming lookups,
// boundaries, back-pressure, exhaustive log round-trip and reset during a stall.
module tb_gf_exp;

    logic       clk;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] in;
    logic       req_zero;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] out;
    logic       init_done;

    int tests_run;
    int tests_failed;

    gf_exp dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .in        (in),
        .req_zero  (req_zero),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .out       (out),
        .init_done (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Discrete log by repeated doubling in GF(2^8); 255 flags "no log" (zero).
    function automatic int gf_log(input logic [7:0] val);
        logic [7:0] p;
        p = 8'h01;
        for (int i = 0; i < 255; i++) begin
            if (p == val) return i;
            p = {p[6:0], 1'b0} ^ (p[7] ? 8'h1D : 8'h00);
        end
        return 255;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int bad;
        rst = 1'b1; req_valid = 1'b0; in = 8'h00; req_zero = 1'b0; rsp_ready = 1'b1;
        tick();
        tick();
        tests_run++;
        if (init_done !== 1'b0 || req_ready !== 1'b0 || rsp_valid !== 1'b0 || out !== 8'h00) begin
            tests_failed++;
            $display("[TB] FAIL reset_state: got init_done=%b req_ready=%b rsp_valid=%b out=%h, want 0 0 0 00",
                     init_done, req_ready, rsp_valid, out);
        end
        rst = 1'b0;
        req_valid = 1'b1;
        in = 8'h05;
        bad = 0;
        for (int i = 0; i < 255; i++) begin
            if (req_ready !== 1'b0 || init_done !== 1'b0 || rsp_valid !== 1'b0) bad++;
            tick();
        end
        tests_run++;
        if (bad !== 0) begin
            tests_failed++;
            $display("[TB] FAIL init_blocks_requests: got %0d cycles with ready/done/valid high, want 0", bad);
        end
        tests_run++;
        if (init_done !== 1'b1 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL init_done_at_255: got init_done=%b req_ready=%b rsp_valid=%b, want 1 1 0",
                     init_done, req_ready, rsp_valid);
        end
        req_valid = 1'b0;
    endtask

    task automatic test_stream();
        logic [7:0] e   [6];
        logic [7:0] exp [6];
        e   = '{8'h00, 8'h01, 8'h08, 8'h19, 8'hC6, 8'h80};
        exp = '{8'h01, 8'h02, 8'h1D, 8'h03, 8'h07, 8'h85};
        rsp_ready = 1'b1;
        req_zero  = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in = e[i];
            req_valid = 1'b1;
            tests_run++;
            if (req_ready !== 1'b1) begin
                tests_failed++;
                $display("[TB] FAIL stream_ready[%0d]: got req_ready=%b, want 1", i, req_ready);
            end
            tick();
            tests_run++;
            if (rsp_valid !== 1'b1 || out !== exp[i]) begin
                tests_failed++;
                $display("[TB] FAIL stream[e=%h]: got rsp_valid=%b out=%h, want 1 %h", e[i], rsp_valid, out, exp[i]);
            end
        end
        req_valid = 1'b0;
        tick();
        tests_run++;
        if (rsp_valid !== 1'b0 || out !== 8'h85) begin
            tests_failed++;
            $display("[TB] FAIL stream_drain: got rsp_valid=%b out=%h, want 0 85", rsp_valid, out);
        end
    endtask

    task automatic test_boundary();
        logic [7:0] e    [4];
        logic       z    [4];
        logic [7:0] exp  [4];
        e   = '{8'hFF, 8'hFE, 8'h08, 8'hFF};
        z   = '{1'b0, 1'b0, 1'b1, 1'b1};
        exp = '{8'h01, 8'h8E, 8'h00, 8'h00};
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in = e[i];
            req_zero = z[i];
            req_valid = 1'b1;
            tick();
            tests_run++;
            if (rsp_valid !== 1'b1 || out !== exp[i]) begin
                tests_failed++;
                $display("[TB] FAIL boundary[e=%h zero=%b]: got rsp_valid=%b out=%h, want 1 %h",
                         e[i], z[i], rsp_valid, out, exp[i]);
            end
        end
        req_valid = 1'b0;
        req_zero = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b0;
        in = 8'h64;
        req_valid = 1'b1;
        tick();
        tests_run++;
        if (rsp_valid !== 1'b1 || out !== 8'h11 || req_ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL bp_first: got rsp_valid=%b out=%h req_ready=%b, want 1 11 0", rsp_valid, out, req_ready);
        end
        in = 8'h32;
        tick();
        tick();
        tests_run++;
        if (rsp_valid !== 1'b1 || out !== 8'h11 || req_ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL bp_hold: got rsp_valid=%b out=%h req_ready=%b, want 1 11 0", rsp_valid, out, req_ready);
        end
        rsp_ready = 1'b1;
        #1;
        tests_run++;
        if (req_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL bp_release_ready: got req_ready=%b, want 1", req_ready);
        end
        tick();
        tests_run++;
        if (rsp_valid !== 1'b1 || out !== 8'h05) begin
            tests_failed++;
            $display("[TB] FAIL bp_replace: got rsp_valid=%b out=%h, want 1 05", rsp_valid, out);
        end
        req_valid = 1'b0;
        tick();
        tick();
        tests_run++;
        if (rsp_valid !== 1'b0 || out !== 8'h05) begin
            tests_failed++;
            $display("[TB] FAIL bp_retain: got rsp_valid=%b out=%h, want 0 05", rsp_valid, out);
        end
    endtask

    task automatic test_sweep();
        bit seen [256];
        int bad_log;
        int dup;
        int lg;
        bad_log = 0;
        dup = 0;
        for (int i = 0; i < 256; i++) seen[i] = 1'b0;
        rsp_ready = 1'b1;
        req_zero = 1'b0;
        req_valid = 1'b1;
        for (int i = 0; i < 255; i++) begin
            in = 8'(i);
            tick();
            lg = gf_log(out);
            if (rsp_valid !== 1'b1 || lg != i) begin
                bad_log++;
                if (bad_log <= 4)
                    $display("[TB] FAIL sweep_log[e=%0d]: got out=%h log=%0d, want log=%0d", i, out, lg, i);
            end
            if (seen[out]) dup++;
            seen[out] = 1'b1;
        end
        req_valid = 1'b0;
        tick();
        tests_run++;
        if (bad_log !== 0) begin
            tests_failed++;
            $display("[TB] FAIL sweep_log_total: got %0d bad entries, want 0", bad_log);
        end
        tests_run++;
        if (dup !== 0) begin
            tests_failed++;
            $display("[TB] FAIL sweep_unique: got %0d repeated outputs, want 0", dup);
        end
    endtask

    task automatic test_reset_stall();
        int cnt;
        rsp_ready = 1'b0;
        in = 8'h08;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tests_run++;
        if (rsp_valid !== 1'b1 || out !== 8'h1D) begin
            tests_failed++;
            $display("[TB] FAIL stall_setup: got rsp_valid=%b out=%h, want 1 1d", rsp_valid, out);
        end
        rst = 1'b1;
        #1;
        tests_run++;
        if (rsp_valid !== 1'b0 || out !== 8'h00 || init_done !== 1'b0 || req_ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL stall_reset_async: got rsp_valid=%b out=%h init_done=%b req_ready=%b, want 0 00 0 0",
                     rsp_valid, out, init_done, req_ready);
        end
        tick();
        rst = 1'b0;
        rsp_ready = 1'b1;
        cnt = 0;
        while (init_done !== 1'b1 && cnt < 400) begin
            tick();
            cnt++;
        end
        tests_run++;
        if (cnt !== 255) begin
            tests_failed++;
            $display("[TB] FAIL reinit_cycles: got %0d, want 255", cnt);
        end
        in = 8'h19;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tests_run++;
        if (rsp_valid !== 1'b1 || out !== 8'h03) begin
            tests_failed++;
            $display("[TB] FAIL reinit_lookup: got rsp_valid=%b out=%h, want 1 03", rsp_valid, out);
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        test_reset();
        test_stream();
        test_boundary();
        test_backpressure();
        test_sweep();
        test_reset_stall();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
